serial_acc_adder: RTL

Bit-serial accumulator adder for the accumulator-based processor datapath. Feeds the accumulator and an operand one bit per cycle, LSB first, through a single gate-level full-adder cell, with a registered carry between bits. Writes the sum back into the accumulator. Sits directly downstream of the full-adder cell: it instantiates one cell and sequences its inputs and outputs. Trades WIDTH cycles of latency for one adder cell.

---
 rtl/serial_acc_adder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/serial_acc_adder.sv
// Bit-serial accumulator adder: one full-adder cell, LSB first, registered carry between bits.
// Optional subtract path enabled by defining SERIAL_SUB_EN (default build is add-only).

module serial_acc_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);
    logic p;
    assign p    = a_i ^ b_i;
    assign s_o  = p ^ ci_i;
    assign co_o = (a_i & b_i) | (p & ci_i);
endmodule

module serial_acc_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acc_load,
    input  logic [WIDTH-1:0] acc_din,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] acc_q,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             zero,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt_q;
    logic             cf_q;
    logic             busy_q, done_q, carry_q, zero_q, ovf_q;
    logic             fa_s, fa_co;
    logic [WIDTH-1:0] b_seed_d;
    logic             cf_seed_d;

`ifdef SERIAL_SUB_EN
    // Subtract as ACC + ~B + 1: invert B on load and seed the carry with the +1.
    assign b_seed_d  = op_sub ? ~operand_b : operand_b;
    assign cf_seed_d = op_sub;
`else
    logic unused_op_sub;
    assign unused_op_sub = op_sub;
    assign b_seed_d      = operand_b;
    assign cf_seed_d     = 1'b0;
`endif

    serial_acc_fa u_fa (
        .a_i  (acc_q[0]),
        .b_i  (b_q[0]),
        .ci_i (cf_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            cf_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (acc_load) begin
                        acc_q <= acc_din;
                    end else if (start) begin
                        b_q     <= b_seed_d;
                        cf_q    <= cf_seed_d;
                        cnt_q   <= '0;
                        carry_q <= 1'b0;
                        zero_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Sum re-enters at the MSB so the accumulator rotates into the result.
                    acc_q <= {fa_s, acc_q[WIDTH-1:1]};
                    b_q   <= {1'b0, b_q[WIDTH-1:1]};
                    cf_q  <= fa_co;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        ovf_q   <= cf_q ^ fa_co;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    carry_q <= cf_q;
                    zero_q  <= (acc_q == '0);
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign carry = carry_q;
    assign zero  = zero_q;
    assign ovf   = ovf_q;
endmodule
